// File: rtl/sfx_arbiter.sv
// Fixed-priority arbiter sharing the Audio tone-select among four sound-effect requesters.
// Optional macro SFX_PREEMPT_EN lets a higher pending request cut short the tone being played.
module sfx_arbiter #(
    parameter int TONE_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       en,
    output logic [2:0] sel,
    output logic [3:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [3:0]       pending_reg, pending_next;
    logic [3:0]       req_d_reg;
    logic [3:0]       rise;
    logic [3:0]       clear;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       sel_reg, sel_next;
    logic [3:0]       grant_reg, grant_next;
    logic [1:0]       top_idx;
    logic             top_valid;

    assign rise = req & ~req_d_reg;

    // Highest set pending bit wins; player dead (bit 3) outranks everything.
    always_comb begin
        top_idx   = 2'd0;
        top_valid = |pending_reg;
        for (int i = 0; i < 4; i++) begin
            if (pending_reg[i]) begin
                top_idx = i[1:0];
            end
        end
    end

    // A fresh rise beats a same-cycle grant clear, so the bit stays pending.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pending
            assign pending_next[gi] = en & (rise[gi] | (pending_reg[gi] & ~clear[gi]));
        end
    endgenerate

`ifdef SFX_PREEMPT_EN
    logic [2:0] owner_idx;
    logic       preempt;
    assign owner_idx = sel_reg - 3'd1;
    assign preempt   = top_valid && ({1'b0, top_idx} > owner_idx);
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        grant_next = grant_reg;
        clear      = 4'b0000;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
            sel_next   = 3'd0;
            grant_next = 4'b0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (top_valid) begin
                        state_next = PLAY;
                        cnt_next   = '0;
                        sel_next   = {1'b0, top_idx} + 3'd1;
                        grant_next = 4'b0001 << top_idx;
                        clear      = 4'b0001 << top_idx;
                    end
                end
                PLAY: begin
`ifdef SFX_PREEMPT_EN
                    if (preempt) begin
                        cnt_next   = '0;
                        sel_next   = {1'b0, top_idx} + 3'd1;
                        grant_next = 4'b0001 << top_idx;
                        clear      = 4'b0001 << top_idx;
                    end else
`endif
                    if (cnt_reg == TONE_LAST) begin
                        state_next = GAP;
                        cnt_next   = '0;
                        sel_next   = 3'd0;
                        grant_next = 4'b0000;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    sel_next   = 3'd0;
                    grant_next = 4'b0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            pending_reg <= 4'b0000;
            req_d_reg   <= 4'b0000;
            cnt_reg     <= '0;
            sel_reg     <= 3'd0;
            grant_reg   <= 4'b0000;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            req_d_reg   <= req;
            cnt_reg     <= cnt_next;
            sel_reg     <= sel_next;
            grant_reg   <= grant_next;
        end
    end

    assign sel   = sel_reg;
    assign grant = grant_reg;
    assign busy  = (state_reg != IDLE) || (|pending_reg);

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed scoreboard bench for sfx_arbiter with TONE_CYCLES=8, GAP_CYCLES=2.
// Build with SFX_PREEMPT_EN defined to check the preemption expectations instead.
module tb_sfx_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       en;
    logic [2:0] sel;
    logic [3:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] grant;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    sfx_arbiter #(
        .TONE_CYCLES(8),
        .GAP_CYCLES (2),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .en   (en),
        .sel  (sel),
        .grant(grant),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Each entry describes the outputs expected at one upcoming falling edge.
    task automatic push(input int n, input logic [2:0] s, input logic [3:0] g, input logic b);
        exp_t e;
        e.sel   = s;
        e.grant = g;
        e.busy  = b;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (exp_q.size() != 0 && t < 2000);
        #1;
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        checks++;
        assert ($onehot0(grant)) else begin
            errors++;
            $error("FAIL grant_onehot: got %b expected at most one bit", grant);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sel", sel, e.sel);
            chk("grant", grant, e.grant);
            chk("busy", busy, e.busy);
            $display("t=%0t sel=%0d grant=%b busy=%0d exp sel=%0d grant=%b busy=%0d",
                     $time, sel, grant, busy, e.sel, e.grant, e.busy);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        #2 rst = 1'b0;
        #1;
        chk("reset_sel", sel, 0);
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        #20 rst = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;

        // Single move pulse: tone 8 cycles, gap 2, then idle.
        req = 4'b0001;
        push(1, 3'd0, 4'b0000, 1'b0);
        push(1, 3'd0, 4'b0000, 1'b1);
        push(8, 3'd1, 4'b0001, 1'b1);
        push(2, 3'd0, 4'b0000, 1'b1);
        push(1, 3'd0, 4'b0000, 1'b0);
        @(posedge clk); #1 req = 4'b0000;
        drain();

        // Simultaneous collision + level complete: level first, then collision.
        req = 4'b0110;
        push(1, 3'd0, 4'b0000, 1'b0);
        push(1, 3'd0, 4'b0000, 1'b1);
        push(8, 3'd3, 4'b0100, 1'b1);
        push(3, 3'd0, 4'b0000, 1'b1);
        push(8, 3'd2, 4'b0010, 1'b1);
        push(2, 3'd0, 4'b0000, 1'b1);
        push(1, 3'd0, 4'b0000, 1'b0);
        @(posedge clk); #1 req = 4'b0000;
        drain();

        // Held collision request plays once only.
        req = 4'b0010;
        push(1, 3'd0, 4'b0000, 1'b0);
        push(1, 3'd0, 4'b0000, 1'b1);
        push(8, 3'd2, 4'b0010, 1'b1);
        push(2, 3'd0, 4'b0000, 1'b1);
        push(40, 3'd0, 4'b0000, 1'b0);
        repeat (50) @(posedge clk);
        #1 req = 4'b0000;
        drain();

        // Disable mid-tone: tone stops, pending level-complete is dropped.
        req = 4'b0001;
        push(1, 3'd0, 4'b0000, 1'b0);
        push(1, 3'd0, 4'b0000, 1'b1);
        push(3, 3'd1, 4'b0001, 1'b1);
        push(20, 3'd0, 4'b0000, 1'b0);
        @(posedge clk); #1 req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1 req = 4'b0100;
        @(posedge clk); #1 begin req = 4'b0000; en = 1'b0; end
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        drain();

        // Player dead arrives during the move tone.
        req = 4'b0001;
        push(1, 3'd0, 4'b0000, 1'b0);
        push(1, 3'd0, 4'b0000, 1'b1);
`ifdef SFX_PREEMPT_EN
        push(4, 3'd1, 4'b0001, 1'b1);
        push(8, 3'd4, 4'b1000, 1'b1);
        push(2, 3'd0, 4'b0000, 1'b1);
        push(1, 3'd0, 4'b0000, 1'b0);
`else
        push(8, 3'd1, 4'b0001, 1'b1);
        push(3, 3'd0, 4'b0000, 1'b1);
        push(8, 3'd4, 4'b1000, 1'b1);
        push(2, 3'd0, 4'b0000, 1'b1);
        push(1, 3'd0, 4'b0000, 1'b0);
`endif
        @(posedge clk); #1 req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 req = 4'b1000;
        @(posedge clk); #1 req = 4'b0000;
        drain();

        // Asynchronous reset mid-tone with a pending request outstanding.
        req = 4'b0001;
        push(1, 3'd0, 4'b0000, 1'b0);
        push(1, 3'd0, 4'b0000, 1'b1);
        push(3, 3'd1, 4'b0001, 1'b1);
        @(posedge clk); #1 req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1 req = 4'b0100;
        @(posedge clk); #1 req = 4'b0000;
        @(posedge clk); #3 rst = 1'b0;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        push(12, 3'd0, 4'b0000, 1'b0);
        drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfx_arbiter.md
Name: sfx_arbiter

Overview:
- Shares the single Audio tone-select input among four sound-effect requesters: move, wall collision, level complete, player dead.
- Sits between the game-side event sources (PlayerObject, Scrolls, FSM) and Audio.sel; replaces the direct button-decoder drive.
- Latches request edges, grants by fixed priority, and holds each tone for a fixed duration followed by a silent gap.

Parameters:
- TONE_CYCLES, 25000000: clock cycles a granted tone is held on sel (0.25 s at 100 MHz); must be >= 1.
- GAP_CYCLES, 1000000: silent cycles (sel=0) after each tone before the next grant; must be >= 1.
- CNT_W, 32: width of the shared duration counter; must hold max(TONE_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- req  input  4  request levels; [0] move, [1] collision, [2] level complete, [3] player dead (highest priority)
- en  input  1  audio enable; low = arbiter silenced
- sel  output  3  tone code to Audio; 0 = silence, requester i = i+1
- grant  output  4  one-hot, current tone owner; 0 when not playing
- busy  output  1  high when state != IDLE or any pending bit is set

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pending=0, req_d=0, counter=0, sel=0, grant=0, busy=0.
- Edge detect: rise = req & ~req_d; req_d <= req every cycle. A held-high req produces exactly one request.
- Pending: pending[i] is set on rise[i] and cleared when i is granted. If set and clear coincide, set wins and the bit stays pending.
- en=0:
  - pending is forced to 0 and rises are ignored.
  - From any state, go to IDLE next edge: sel=0, grant=0, counter=0.
- States: IDLE, PLAY, GAP.
- IDLE:
  - If en=1 and pending!=0, grant the highest set bit p.
  - Next edge: state=PLAY, grant=1<<p, sel=p+1, counter=0, pending[p] cleared.
- PLAY:
  - Counter increments each cycle.
  - When counter==TONE_CYCLES-1: state=GAP, counter=0, sel=0, grant=0. Tone lasts exactly TONE_CYCLES cycles.
- GAP:
  - sel=0; counter increments.
  - When counter==GAP_CYCLES-1: state=IDLE.
  - No grant is issued during GAP.
- Latency: rise sampled at edge E0 sets pending at E0; sel/grant valid after E1 when in IDLE.
- Ties: simultaneous rises on several bits all become pending; they are served highest-first, each with its own tone+gap.
- Counter never wraps; it is compared against parameter bounds and reset on every state change.
- sel and grant are registered outputs, glitch-free; grant is always one-hot or zero.

Optional Feature:
- Macro SFX_PREEMPT_EN.
- Defined:
  - In PLAY, if the highest pending bit q > current owner, next edge regrants q: grant=1<<q, sel=q+1, counter=0, pending[q] cleared.
  - The preempted request is dropped, not re-queued.
  - Preemption is not evaluated in GAP.
- Undefined: no preemption; higher requests wait for the current tone and gap to finish.

Test Plan (TONE_CYCLES=8, GAP_CYCLES=2, en=1 unless stated):
- Reset, then pulse req=4'b0001 for 1 cycle -> sel=1, grant=0001 for exactly 8 cycles starting 2 edges after the pulse; then sel=0 for 2 cycles; then IDLE with busy=0.
- req=4'b0110 in the same cycle -> sel=3 for 8 cycles, 2-cycle gap, then sel=2 for 8 cycles; no cycle with grant carrying two bits.
- Hold req[1] high for 50 cycles -> exactly one collision tone (sel=2 for 8 cycles), not repeated.
- During a move tone, deassert en at cycle 3 -> sel=0 and grant=0 on the next edge; a pending req[2] is discarded; re-asserting en plays nothing.
- With SFX_PREEMPT_EN: move tone at cycle 3, pulse req[3] -> sel=4 for a full 8 cycles, move is not replayed. Without the macro -> move completes 8 cycles, 2-cycle gap, then sel=4.
- Assert rst=0 mid-PLAY, asynchronously between clock edges -> sel, grant and busy go to 0 immediately; pending is empty after release.
